usr_ctrl: RTL and testbench

Command sequencer that drives the 4-bit universal shift register (`usr`) from a valid/ready command port. It sits directly upstream of `usr`: it accepts clear, load and multi-step shift commands, generates the per-cycle mode select, serial-in bits and parallel data, and then returns the resulting register contents on a one-cycle response strobe. It has no storage of its own beyond the sequencing state; the data register is the downstream `usr` instance.

---
 rtl/usr_pkg.sv | 27 ++
 rtl/usr.sv | 34 +++
 rtl/usr_ctrl.sv | 121 ++++++++++++
 tb/tb_usr_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register and its command sequencer.
package usr_pkg;

    // Command opcodes on the valid/ready port
    typedef enum logic [1:0] {
        OP_CLR  = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    // Mode select understood by usr
    typedef enum logic [1:0] {
        S_HOLD = 2'b00,
        S_SHR  = 2'b01,
        S_SHL  = 2'b10,
        S_LOAD = 2'b11
    } mode_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/usr.sv
// Universal shift register: hold, shift right, shift left, parallel load, sync clear.
module usr
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       s,
    input  logic             sisr,
    input  logic             sisl,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Register update selected by mode; clear has priority
    always_ff @(posedge clk) begin
        if (clear) begin
            r_q <= '0;
        end else begin
            case (mode_e'(s))
                S_SHR:   r_q <= {sisr, r_q[WIDTH-1:1]};
                S_SHL:   r_q <= {r_q[WIDTH-2:0], sisl};
                S_LOAD:  r_q <= pin;
                default: r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule

// File: rtl/usr_ctrl.sv
// Command sequencer driving usr: accepts CLR/LOAD/SHR/SHL, returns contents on a strobe.
module usr_ctrl
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_q,
    output logic             usr_clear,
    output logic [1:0]       usr_s,
    output logic             usr_sisr,
    output logic             usr_sisl,
    output logic [WIDTH-1:0] usr_pin,
    input  logic [WIDTH-1:0] usr_q
);

    state_e           r_state;
    op_e              r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sdat;
    logic             r_ready;
    logic             r_rsp_valid;
    logic             r_clear;
    logic [1:0]       r_s;
    logic             r_sisr;
    logic             r_sisl;
    logic [WIDTH-1:0] r_pin;
    op_e              w_op;
    logic             w_shift_op;

    assign w_op       = op_e'(cmd_op);
    assign w_shift_op = (r_op == OP_SHR) || (r_op == OP_SHL);

    // Sequencing FSM; every usr_* output is registered one edge ahead of its RUN cycle
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_CLR;
            r_cnt       <= '0;
            r_sdat      <= '0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_clear     <= 1'b0;
            r_s         <= S_HOLD;
            r_sisr      <= 1'b0;
            r_sisl      <= 1'b0;
            r_pin       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b0;
                        r_op    <= w_op;
                        r_cnt   <= cmd_cnt;
                        // First serial bit goes straight to the output, so sdat
                        // holds the remaining bits already shifted by one.
                        r_sdat  <= cmd_data >> 1;
                        case (w_op)
                            OP_CLR:  r_clear <= 1'b1;
                            OP_LOAD: begin
                                r_s   <= S_LOAD;
                                r_pin <= cmd_data;
                            end
                            OP_SHR: if (cmd_cnt != '0) begin
                                r_s    <= S_SHR;
                                r_sisr <= cmd_data[0];
                            end
                            default: if (cmd_cnt != '0) begin
                                r_s    <= S_SHL;
                                r_sisl <= cmd_data[0];
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    if (w_shift_op && (r_cnt > CNT_W'(1))) begin
                        r_cnt  <= r_cnt - 1'b1;
                        r_sdat <= r_sdat >> 1;
                        if (r_op == OP_SHR) r_sisr <= r_sdat[0];
                        else                r_sisl <= r_sdat[0];
                    end else begin
                        r_state     <= ST_DONE;
                        r_cnt       <= '0;
                        r_sdat      <= '0;
                        r_rsp_valid <= 1'b1;
                        r_clear     <= 1'b0;
                        r_s         <= S_HOLD;
                        r_sisr      <= 1'b0;
                        r_sisl      <= 1'b0;
                        r_pin       <= '0;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_ready     <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_q     = r_rsp_valid ? usr_q : '0;
    assign usr_clear = r_clear;
    assign usr_s     = r_s;
    assign usr_sisr  = r_sisr;
    assign usr_sisl  = r_sisl;
    assign usr_pin   = r_pin;

endmodule

// File: tb/tb_usr_ctrl.sv
// Self-checking bench: usr_ctrl driving a real usr, checked against a behavioural model.
module tb_usr_ctrl;
    import usr_pkg::*;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned MASK  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             clear_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = '0;
    logic [CNT_W-1:0] cmd_cnt = '0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             cmd_ready;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_q;
    logic             usr_clear;
    logic [1:0]       usr_s;
    logic             usr_sisr;
    logic             usr_sisl;
    logic [WIDTH-1:0] usr_pin;
    logic [WIDTH-1:0] usr_q;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned mdl    = 0;

    usr_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .clear_n(clear_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_q(rsp_q), .usr_clear(usr_clear), .usr_s(usr_s),
        .usr_sisr(usr_sisr), .usr_sisl(usr_sisl), .usr_pin(usr_pin), .usr_q(usr_q)
    );

    usr #(.WIDTH(WIDTH)) u_usr (
        .clk(clk), .clear(usr_clear), .s(usr_s), .sisr(usr_sisr), .sisl(usr_sisl),
        .pin(usr_pin), .q(usr_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // While the block is busy, optionally keep a changing command on the port
    task automatic drive_busy(input bit junk);
        if (junk) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_cnt   = CNT_W'($urandom_range(0, 7));
            cmd_data  = WIDTH'($urandom_range(0, MASK));
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    // Model one shift step on the abstract register value
    task automatic model_step(input bit right, input int unsigned b);
        if (right) mdl = (mdl >> 1) | (b << (WIDTH - 1));
        else       mdl = ((mdl << 1) | b) & MASK;
    endtask

    // Issue one command at a negedge in IDLE and follow it to the first IDLE cycle after
    task automatic do_cmd(input logic [1:0] op, input int unsigned cnt,
                          input int unsigned data, input bit junk);
        int unsigned n;
        int unsigned b;
        bit          is_shift;
        is_shift  = (op == 2'b01) || (op == 2'b10);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = CNT_W'(cnt);
        cmd_data  = WIDTH'(data);
        chk("ready_idle", cmd_ready, 1);
        chk("rsp_gated", rsp_q, 0);
        @(posedge clk);
        n = (is_shift && cnt != 0) ? cnt : 1;
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk);
            drive_busy(junk);
            chk("ready_run", cmd_ready, 0);
            chk("rsp_run", rsp_valid, 0);
            if (op == 2'b00) begin
                chk("clr_clear", usr_clear, 1);
                chk("clr_s", usr_s, S_HOLD);
                mdl = 0;
            end else if (op == 2'b11) begin
                chk("ld_s", usr_s, S_LOAD);
                chk("ld_pin", usr_pin, data & MASK);
                chk("ld_clear", usr_clear, 0);
                mdl = data & MASK;
            end else if (cnt == 0) begin
                chk("nop_s", usr_s, S_HOLD);
            end else begin
                b = (k < WIDTH) ? ((data >> k) & 1) : 0;
                chk("sh_pin", usr_pin, 0);
                if (op == 2'b01) begin
                    chk("shr_s", usr_s, S_SHR);
                    chk("shr_sisr", usr_sisr, b);
                    chk("shr_sisl", usr_sisl, 0);
                end else begin
                    chk("shl_s", usr_s, S_SHL);
                    chk("shl_sisl", usr_sisl, b);
                    chk("shl_sisr", usr_sisr, 0);
                end
                model_step(op == 2'b01, b);
            end
        end
        @(negedge clk);
        drive_busy(junk);
        chk("done_valid", rsp_valid, 1);
        chk("done_q", rsp_q, mdl);
        chk("done_s", usr_s, S_HOLD);
        chk("done_clear", usr_clear, 0);
        chk("done_ready", cmd_ready, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("idle_valid", rsp_valid, 0);
        chk("idle_ready", cmd_ready, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_q", rsp_q, 0);
        chk("rst_s", usr_s, S_HOLD);
        chk("rst_clear", usr_clear, 0);
        chk("rst_serial", {usr_sisr, usr_sisl}, 0);
        chk("rst_pin", usr_pin, 0);
        clear_n = 1'b1;

        do_cmd(2'b00, 0, 4'b0000, 1'b0);
        do_cmd(2'b11, 0, 4'b1011, 1'b0);
        do_cmd(2'b01, 2, 4'b0001, 1'b0);
        chk("plan_shr", mdl, 4'b0110);
        do_cmd(2'b10, 3, 4'b0101, 1'b0);
        chk("plan_shl", mdl, 4'b0101);
        do_cmd(2'b10, 0, 4'b1111, 1'b0);
        do_cmd(2'b11, 0, 4'b1001, 1'b1);
        do_cmd(2'b01, 7, 4'b1101, 1'b1);

        // Abort an SHR of 5 after two steps have reached usr
        do_cmd(2'b11, 0, 4'b1111, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_cnt   = CNT_W'(5);
        cmd_data  = 4'b0110;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        model_step(1'b1, 0);
        @(negedge clk);
        model_step(1'b1, 1);
        @(negedge clk);
        clear_n = 1'b0;
        #1;
        chk("abort_s", usr_s, S_HOLD);
        chk("abort_serial", {usr_sisr, usr_sisl}, 0);
        chk("abort_valid", rsp_valid, 0);
        chk("abort_usr_q", usr_q, mdl);
        @(negedge clk);
        chk("abort_hold_q", usr_q, mdl);
        chk("abort_no_rsp", rsp_valid, 0);
        clear_n = 1'b1;
        do_cmd(2'b11, 0, 4'b0011, 1'b0);
        chk("abort_reload", mdl, 4'b0011);

        for (int i = 0; i < 40; i++) begin
            do_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 7),
                   $urandom_range(0, MASK), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
